// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: state codes, opcode/func constants and ALUop codes for the multi-cycle MIPS controller
package multicycle_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_RD = 4'd3, S_MEM_WB = 4'd4,
    S_MEM_WR = 4'd5, S_R_EXE = 4'd6, S_R_WB = 4'd7, S_BEQ = 4'd8, S_JUMP = 4'd9,
    S_JR = 4'd10, S_ADDI_EXE = 4'd11, S_ADDI_WB = 4'd12
  } state_e;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] FUNC_ADD = 6'b100000;
  localparam logic [5:0] FUNC_SUB = 6'b100010;
  localparam logic [5:0] FUNC_AND = 6'b100100;
  localparam logic [5:0] FUNC_OR  = 6'b100101;
  localparam logic [5:0] FUNC_SLT = 6'b101010;
  localparam logic [5:0] FUNC_JR  = 6'b001000;
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;
  function automatic logic func_ok(input logic [5:0] f);
    return f inside {FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_OR, FUNC_SLT, FUNC_JR};
  endfunction
endpackage

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: counts memory wait cycles and flags a timeout when the limit is reached without ready
module mc_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ready,
  input  logic clr,
  output logic timeout
);
  logic [7:0] cnt_q, cnt_d;
  always_comb begin
    timeout = active && !ready && (cnt_q == 8'(MEM_TIMEOUT));
    // timeout in FETCH keeps the state unchanged, so it must clear the count itself
    cnt_d = (clr || timeout) ? 8'd0 : (active && !ready) ? cnt_q + 8'd1 : cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= 8'd0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore main controller for the multi-cycle MIPS datapath with memory
// ready handshake and wait timeout
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state
);
  state_e state_q, state_d;
  logic pc_write, pc_write_cond, timeout;
  mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk(clk), .rst(rst),
    .active(state_q inside {S_FETCH, S_MEM_RD, S_MEM_WR}),
    .ready(mem_ready), .clr(state_d != state_q), .timeout(timeout)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= S_FETCH;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    pc_write = 1'b0;
    pc_write_cond = 1'b0;
    iord = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_op = ALUOP_ADD;
    pc_source = 2'b00;
    instr_done = 1'b0;
    illegal = 1'b0;
    bus_err = timeout;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        alu_src_b = 2'b01;
        ir_write = mem_ready;
        pc_write = mem_ready;
        state_d = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        illegal = !(op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI}) ||
                  (op == OP_RTYPE && !func_ok(func));
        state_d = illegal ? S_FETCH :
                  (op == OP_LW || op == OP_SW) ? S_MEM_ADDR :
                  op == OP_BEQ ? S_BEQ :
                  op == OP_J ? S_JUMP :
                  op == OP_ADDI ? S_ADDI_EXE :
                  func == FUNC_JR ? S_JR : S_R_EXE;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d = op == OP_SW ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord = 1'b1;
        state_d = mem_ready ? S_MEM_WB : timeout ? S_FETCH : S_MEM_RD;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord = 1'b1;
        instr_done = mem_ready;
        state_d = (mem_ready || timeout) ? S_FETCH : S_MEM_WR;
      end
      S_MEM_WB: begin
        reg_write = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d = S_FETCH;
      end
      S_R_EXE: begin
        alu_src_a = 1'b1;
        alu_op = ALUOP_FUNC;
        state_d = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst = 1'b1;
        instr_done = 1'b1;
        state_d = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = 1'b1;
        alu_op = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source = 2'b01;
        instr_done = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_source = 2'b10;
        instr_done = 1'b1;
        state_d = S_FETCH;
      end
      S_JR: begin
        pc_write = 1'b1;
        pc_source = 2'b11;
        instr_done = 1'b1;
        state_d = S_FETCH;
      end
      S_ADDI_EXE: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
        instr_done = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    pc_en = pc_write | (pc_write_cond & zero);
    // FETCH strobes would otherwise be live while reset holds the state at FETCH
    if (rst) {pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
              alu_src_a, alu_src_b, alu_op, pc_source, instr_done, illegal, bus_err} = '0;
  end
  assign state = state_q;
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style main controller for the multi-cycle MIPS datapath.
- Sequences one instruction over 3–5 states, plus memory wait cycles.
- Drives datapath muxes, enables and the 2-bit ALUop into the existing ALU-control decoder.
- Holds memory strobes until a ready handshake, and aborts on a memory timeout.

Parameters:
- MEM_TIMEOUT, 16: maximum wait cycles for mem_ready in any memory state before abort. Legal range 1–255.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous active-high reset
- op  in  6  IR[31:26]
- func  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current read or write this cycle
- pc_en  out  1  PC load = pc_write | (pc_write_cond & zero)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load
- mem_to_reg  out  1  write-back source: 1 = MDR
- reg_dst  out  1  destination register: 1 = rd, 0 = rt
- reg_write  out  1  register file write
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = A
- alu_src_b  out  2  ALU B input: 00 = B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- alu_op  out  2  00 = add, 01 = sub, 10 = decode func
- pc_source  out  2  00 = ALU, 01 = ALUOut, 10 = jump target, 11 = A (jr)
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- illegal  out  1  one-cycle pulse on an unknown op, or an R-type func outside {add, sub, and, or, slt, jr}
- bus_err  out  1  one-cycle pulse when a memory wait times out
- state  out  4  current state, for debug

Behaviour:
- Reset:
  - state goes to FETCH asynchronously; wait counter clears to 0.
  - While rst = 1, every output is 0, including the FETCH strobes.
- State encoding:
  - FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_RD = 3, MEM_WB = 4, MEM_WR = 5, R_EXE = 6.
  - R_WB = 7, BEQ = 8, JUMP = 9, JR = 10, ADDI_EXE = 11, ADDI_WB = 12.
  - Codes 13–15 are unreachable; if entered, go to FETCH on the next edge.
- Outputs per state (every output not listed is 0):
  - FETCH: mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00. ir_write and pc_write = 1 only in the cycle mem_ready = 1.
  - DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 00 (branch target into ALUOut).
  - MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 00.
  - MEM_RD: mem_read = 1, iord = 1.
  - MEM_WR: mem_write = 1, iord = 1.
  - MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0.
  - R_EXE: alu_src_a = 1, alu_src_b = 00, alu_op = 10.
  - R_WB: reg_write = 1, reg_dst = 1.
  - BEQ: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 01.
  - JUMP: pc_write = 1, pc_source = 10.
  - JR: pc_write = 1, pc_source = 11.
  - ADDI_EXE: alu_src_a = 1, alu_src_b = 10, alu_op = 00.
  - ADDI_WB: reg_write = 1, reg_dst = 0.
- Transitions:
  - FETCH → DECODE on mem_ready; otherwise stay.
  - DECODE, by op:
    - 100011 (lw) or 101011 (sw) → MEM_ADDR
    - 000000 with func 001000 → JR
    - other 000000 → R_EXE
    - 000100 → BEQ
    - 000010 → JUMP
    - 001000 → ADDI_EXE
    - anything else → FETCH, with illegal pulsed in DECODE
  - An R-type func outside {100000, 100010, 100100, 100101, 101010, 001000} also goes DECODE → FETCH with illegal pulsed.
  - MEM_ADDR → MEM_RD for lw, MEM_WR for sw.
  - MEM_RD → MEM_WB on mem_ready; MEM_WR → FETCH on mem_ready.
  - R_EXE → R_WB; ADDI_EXE → ADDI_WB.
  - R_WB, MEM_WB, ADDI_WB, BEQ, JUMP, JR → FETCH.
- instr_done:
  - Pulses in R_WB, MEM_WB, ADDI_WB, BEQ, JUMP, JR.
  - Pulses in MEM_WR on the mem_ready cycle.
- Memory wait and timeout:
  - The wait counter increments every cycle in FETCH, MEM_RD or MEM_WR while mem_ready = 0, and clears on every state change.
  - When it reaches MEM_TIMEOUT with mem_ready still 0: bus_err pulses, the next state is FETCH, and no write enable fires.
  - mem_ready on the same cycle as the limit counts as success, not timeout.
  - mem_ready outside the memory states is ignored.
- op and func are sampled only in DECODE and MEM_ADDR; the IR is stable there by construction.
- Cycle counts with zero-wait memory: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, jr 3.

Decomposition:
- Shared package holds:
  - state localparams
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - FUNC_JR and the other func constants
  - ALUOP_ADD / SUB / FUNC codes
- One sub-module, mc_wait_timer: counter, clear, and limit compare, parameterised by MEM_TIMEOUT.

Test Plan:
- Reset release, lw, mem_ready delayed: release rst, feed lw with mem_ready delayed 2 cycles in FETCH and 1 cycle in MEM_RD.
  - State sequence 0,0,0,1,2,3,3,4.
  - ir_write pulses exactly once; reg_write = 1 with mem_to_reg = 1 in state 4; instr_done pulses once.
- R-type add, zero-wait memory (func 100000): states 0,1,6,7; alu_op = 10 in state 6; reg_dst = 1, reg_write = 1 in state 7.
- beq: with zero = 1, pc_en = 1 in state 8. With zero = 0, pc_en = 0 and the next state is still FETCH.
- jr and j:
  - jr (op 000000, func 001000): states 0,1,10; pc_source = 11, pc_en = 1.
  - j: state 9, pc_source = 10.
- Illegal op 111111: illegal pulses in DECODE, the next state is 0, and no write strobes fire.
- Timeout and reset mid-operation:
  - Hold mem_ready = 0 in MEM_WR: bus_err pulses after 16 wait cycles, then FETCH; mem_write drops and instr_done stays 0.
  - Assert rst mid-MEM_RD: outputs go to 0 immediately and state = 0.
